// File: rtl/aes_trojan_trigger.sv
// Watches valid plaintext beats for the four-block trigger sequence and latches ARMED until reset.
// Tj_Trig is registered and rises the cycle after the final matching beat; idle cycles (state_vld=0) hold progress.
module aes_trojan_trigger #(
  parameter logic [127:0] PAT0 = 128'h3243f6a8885a308d313198a2e0370734,
  parameter logic [127:0] PAT1 = 128'h00112233445566778899aabbccddeeff,
  parameter logic [127:0] PAT2 = 128'h00000000000000000000000000000000,
  parameter logic [127:0] PAT3 = 128'hffffffffffffffffffffffffffffffff
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic         state_vld,
  output logic         Tj_Trig,
  output logic [2:0]   seq_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    ARMED = 3'd4
  } fsm_t;

  fsm_t cur_st;
  fsm_t nxt_st;

  // The expected-pattern test is evaluated before the PAT0 restart so it wins when patterns coincide.
  always_comb begin
    nxt_st = cur_st;
    if (state_vld) begin
      case (cur_st)
        IDLE: begin
          if (state == PAT0) nxt_st = S1;
        end
        S1: begin
          if (state == PAT1)      nxt_st = S2;
          else if (state == PAT0) nxt_st = S1;
          else                    nxt_st = IDLE;
        end
        S2: begin
          if (state == PAT2)      nxt_st = S3;
          else if (state == PAT0) nxt_st = S1;
          else                    nxt_st = IDLE;
        end
        S3: begin
          if (state == PAT3)      nxt_st = ARMED;
          else if (state == PAT0) nxt_st = S1;
          else                    nxt_st = IDLE;
        end
        ARMED:   nxt_st = ARMED;
        default: nxt_st = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st  <= IDLE;
      Tj_Trig <= 1'b0;
    end else begin
      cur_st  <= nxt_st;
      Tj_Trig <= (nxt_st == ARMED);
    end
  end

  assign seq_state = cur_st;

endmodule

// File: tb/tb_aes_trojan_trigger.sv
// Directed bench for aes_trojan_trigger: trigger sequence, restarts, idle gaps, reset priority.
module tb_aes_trojan_trigger;

  localparam logic [127:0] PAT0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PAT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PAT2 = 128'h00000000000000000000000000000000;
  localparam logic [127:0] PAT3 = 128'hffffffffffffffffffffffffffffffff;

  logic         clk;
  logic         rst;
  logic [127:0] state;
  logic         state_vld;
  logic         Tj_Trig;
  logic [2:0]   seq_state;

  int checks;
  int failures;

  aes_trojan_trigger dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .state_vld (state_vld),
    .Tj_Trig   (Tj_Trig),
    .seq_state (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check both outputs against the expected FSM state; Tj_Trig must be 1 only in ARMED.
  task automatic expect_st(input string tag, input logic [2:0] exp_s);
    check({tag, ".seq"}, {125'd0, seq_state}, {125'd0, exp_s});
    check({tag, ".trig"}, {127'd0, Tj_Trig}, {127'd0, (exp_s == 3'd4)});
  endtask

  // Called at posedge+1: drive one valid beat, let it be clocked, then go idle with X data.
  task automatic beat(input string tag, input logic [127:0] d, input logic [2:0] exp_s);
    state     = d;
    state_vld = 1'b1;
    @(posedge clk);
    #1;
    state_vld = 1'b0;
    state     = 'x;
    expect_st(tag, exp_s);
  endtask

  task automatic gap(input string tag, input int n, input logic [2:0] exp_s);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      expect_st(tag, exp_s);
    end
  endtask

  task automatic do_rst(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_st(tag, 3'd0);
  endtask

  task automatic to_s3(input string tag);
    beat({tag, ".p0"}, PAT0, 3'd1);
    beat({tag, ".p1"}, PAT1, 3'd2);
    beat({tag, ".p2"}, PAT2, 3'd3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rnd;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    state     = '0;
    state_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_st("reset", 3'd0);

    // Full sequence, then ARMED absorbs 100 random beats.
    to_s3("seq");
    beat("seq.p3", PAT3, 3'd4);
    for (int i = 0; i < 100; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      if (i == 5) rnd = PAT0;
      if (i == 6) rnd = 128'h1;
      beat("armed_hold", rnd, 3'd4);
    end

    do_rst("rst_armed");
    beat("brk.p0", PAT0, 3'd1);
    beat("brk.p1", PAT1, 3'd2);
    beat("brk.one", 128'h1, 3'd0);
    to_s3("brk.again");
    beat("brk.p3", PAT3, 3'd4);

    do_rst("rst2");
    beat("rs.p0", PAT0, 3'd1);
    beat("rs.p1", PAT1, 3'd2);
    beat("rs.p0b", PAT0, 3'd1);
    beat("rs.p1b", PAT1, 3'd2);
    beat("rs.p2", PAT2, 3'd3);
    beat("rs.p3", PAT3, 3'd4);

    // Restart and failure branches from S1 and S3, plus single-bit miss on PAT3.
    do_rst("rst3");
    beat("s1.p0", PAT0, 3'd1);
    beat("s1.p0again", PAT0, 3'd1);
    beat("s1.p2", PAT2, 3'd0);
    to_s3("s3r");
    beat("s3r.p0", PAT0, 3'd1);
    to_s3("s3m");
    beat("s3m.msb", PAT3 ^ {1'b1, 127'd0}, 3'd0);
    to_s3("s3l");
    beat("s3l.lsb", PAT3 ^ 128'd1, 3'd0);
    beat("s2x.p0", PAT0, 3'd1);
    beat("s2x.p1", PAT1, 3'd2);
    beat("s2x.p3", PAT3, 3'd0);

    // Idle gaps with X data hold progress.
    beat("gap.p0", PAT0, 3'd1);
    gap("gap1", 5, 3'd1);
    beat("gap.p1", PAT1, 3'd2);
    gap("gap2", 5, 3'd2);
    beat("gap.p2", PAT2, 3'd3);
    gap("gap3", 5, 3'd3);
    beat("gap.p3", PAT3, 3'd4);

    // Reset beats a concurrent PAT3 in S3; progress is discarded.
    do_rst("rst4");
    to_s3("rp");
    state     = PAT3;
    state_vld = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    state_vld = 1'b0;
    state     = 'x;
    expect_st("rp.rst_p3", 3'd0);
    beat("rp.lone_p3", PAT3, 3'd0);

    // Reset beats a concurrent PAT0 in IDLE.
    state     = PAT0;
    state_vld = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    state_vld = 1'b0;
    state     = 'x;
    expect_st("rp.rst_p0", 3'd0);

    // Reset mid-sequence from S2: remaining two beats alone must not arm.
    beat("mid.p0", PAT0, 3'd1);
    beat("mid.p1", PAT1, 3'd2);
    do_rst("mid.rst");
    beat("mid.p2", PAT2, 3'd0);
    beat("mid.p3", PAT3, 3'd0);

    // Arm, reset, then 10,000 random cycles without the sequence.
    to_s3("arm");
    beat("arm.p3", PAT3, 3'd4);
    do_rst("arm.rst");
    for (int i = 0; i < 10000; i++) begin
      state_vld = 1'($urandom_range(0, 1));
      if (state_vld) state = {$urandom, $urandom, $urandom, $urandom};
      else           state = 'x;
      @(posedge clk);
      #1;
      check("quiet.trig", {127'd0, Tj_Trig}, 128'd0);
    end
    state_vld = 1'b0;
    expect_st("quiet.end", 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
